// File: rtl/sap_pkg.sv
// Shared opcodes, sequencer states and instruction helpers for the SAP-class accumulator core.
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_HALT = 3'd7
    } state_e;

    // Opcodes that go through MAR to reach RAM in T4.
    function automatic logic is_mem_op(input logic [3:0] op);
        case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: is_mem_op = 1'b1;
            default:                        is_mem_op = 1'b0;
        endcase
    endfunction

    // Cycles from T1 entry to the next T1 entry.
    function automatic logic [2:0] instr_len(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA: instr_len = 3'd4;
            OP_ADD, OP_SUB: instr_len = 3'd5;
            default:        instr_len = 3'd3;
        endcase
    endfunction

endpackage

// File: rtl/sap_ram.sv
// Program/data RAM: one synchronous write port and one registered read port, never reset.
module sap_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [0:DEPTH-1];

    // Write lands at the edge; read data is registered for use in the following cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/sap_cpu_core.sv
// Accumulator CPU core: micro-step sequencer, datapath registers, ALU and program-load handshake.
module sap_cpu_core
    import sap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              load_done,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              cf,
    output logic              zf,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_e            state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] mar_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [DATA_W-1:0] ir_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_valid_r;
    logic              cf_r;
    logic              zf_r;
    logic              halted_r;
    logic              prog_ready_r;
    logic              load_done_r;

    logic [3:0]        opcode_s;
    logic [ADDR_W-1:0] operand_s;
    logic [DATA_W-1:0] operand_ext_s;
    logic [ADDR_W-1:0] mar_d_s;
    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_waddr_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic [DATA_W-1:0] ram_rdata_s;
    logic              is_sub_s;
    logic [DATA_W-1:0] alu_b_s;
    logic [DATA_W:0]   alu_sum_s;

    assign opcode_s      = ir_r[DATA_W-1 -: 4];
    assign operand_s     = ir_r[ADDR_W-1:0];
    assign operand_ext_s = {{(DATA_W-ADDR_W){1'b0}}, operand_s};

    // Subtraction is A + ~B + 1, so carry out means "no borrow".
    assign is_sub_s  = (opcode_s == OP_SUB);
    assign alu_b_s   = is_sub_s ? ~b_r : b_r;
    assign alu_sum_s = {1'b0, a_r} + {1'b0, alu_b_s} + {{DATA_W{1'b0}}, is_sub_s};

    // Next MAR value; it also addresses the RAM so the read lands one state later.
    always_comb begin
        mar_d_s = mar_r;
        case (state_r)
            ST_T1: mar_d_s = pc_r;
            ST_T3: begin
                if (is_mem_op(opcode_s)) begin
                    mar_d_s = operand_s;
                end else begin
                    mar_d_s = mar_r;
                end
            end
            default: mar_d_s = mar_r;
        endcase
    end

    // Write port source: program loader in LOAD, accumulator store in T4.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = ptr_r;
        ram_wdata_s = prog_data;
        case (state_r)
            ST_LOAD: ram_we_s = prog_valid & prog_ready_r;
            ST_T4: begin
                if (opcode_s == OP_STA) begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = mar_r;
                    ram_wdata_s = a_r;
                end else begin
                    ram_we_s    = 1'b0;
                end
            end
            default: ram_we_s = 1'b0;
        endcase
    end

    sap_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we_s & ~rst),
        .waddr(ram_waddr_s),
        .wdata(ram_wdata_s),
        .raddr(mar_d_s),
        .rdata(ram_rdata_s)
    );

    // Sequencer, datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pc_r         <= ADDR_ZERO;
            mar_r        <= ADDR_ZERO;
            ptr_r        <= ADDR_ZERO;
            ir_r         <= DATA_ZERO;
            a_r          <= DATA_ZERO;
            b_r          <= DATA_ZERO;
            out_data_r   <= DATA_ZERO;
            out_valid_r  <= 1'b0;
            cf_r         <= 1'b0;
            zf_r         <= 1'b0;
            halted_r     <= 1'b0;
            prog_ready_r <= 1'b0;
            load_done_r  <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            mar_r       <= mar_d_s;
            case (state_r)
                ST_IDLE: begin
                    if (prog_mode) begin
                        state_r      <= ST_LOAD;
                        ptr_r        <= ADDR_ZERO;
                        prog_ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_T1;
                    end
                end
                ST_LOAD: begin
                    if (!prog_mode) begin
                        state_r      <= ST_T1;
                        pc_r         <= ADDR_ZERO;
                        ptr_r        <= ADDR_ZERO;
                        ir_r         <= DATA_ZERO;
                        a_r          <= DATA_ZERO;
                        b_r          <= DATA_ZERO;
                        cf_r         <= 1'b0;
                        zf_r         <= 1'b0;
                        prog_ready_r <= 1'b0;
                        load_done_r  <= 1'b0;
                    end else if (prog_valid && prog_ready_r) begin
                        ptr_r <= ptr_r + ADDR_ONE;
                        if (ptr_r == ADDR_LAST) begin
                            load_done_r  <= 1'b1;
                            prog_ready_r <= 1'b0;
                        end
                    end
                end
                ST_T1: state_r <= ST_T2;
                ST_T2: begin
                    ir_r    <= ram_rdata_s;
                    pc_r    <= pc_r + ADDR_ONE;
                    state_r <= ST_T3;
                end
                ST_T3: begin
                    state_r <= ST_T1;
                    case (opcode_s)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: state_r <= ST_T4;
                        OP_LDI: a_r <= operand_ext_s;
                        OP_JMP: pc_r <= operand_s;
                        OP_JC: begin
                            if (cf_r) begin
                                pc_r <= operand_s;
                            end
                        end
                        OP_JZ: begin
                            if (zf_r) begin
                                pc_r <= operand_s;
                            end
                        end
                        OP_OUT: begin
                            out_data_r  <= a_r;
                            out_valid_r <= 1'b1;
                        end
                        OP_HLT: begin
                            halted_r <= 1'b1;
                            state_r  <= ST_HALT;
                        end
                        default: state_r <= ST_T1;
                    endcase
                end
                ST_T4: begin
                    case (opcode_s)
                        OP_LDA: begin
                            a_r     <= ram_rdata_s;
                            state_r <= ST_T1;
                        end
                        OP_ADD, OP_SUB: begin
                            b_r     <= ram_rdata_s;
                            state_r <= ST_T5;
                        end
                        default: state_r <= ST_T1;
                    endcase
                end
                ST_T5: begin
                    a_r     <= alu_sum_s[DATA_W-1:0];
                    cf_r    <= alu_sum_s[DATA_W];
                    zf_r    <= (alu_sum_s[DATA_W-1:0] == DATA_ZERO);
                    state_r <= ST_T1;
                end
                ST_HALT: begin
                    if (prog_mode) begin
                        state_r      <= ST_LOAD;
                        ptr_r        <= ADDR_ZERO;
                        prog_ready_r <= 1'b1;
                        load_done_r  <= 1'b0;
                        halted_r     <= 1'b0;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign prog_ready = prog_ready_r;
    assign load_done  = load_done_r;
    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign cf         = cf_r;
    assign zf         = zf_r;
    assign halted     = halted_r;

endmodule

// File: tb/tb_sap_cpu_core.sv
// Randomized scoreboard bench for sap_cpu_core against an instruction-level reference model.
module tb_sap_cpu_core;
    import sap_pkg::*;

    logic       clk;
    logic       rst;
    logic       prog_mode;
    logic       prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready;
    logic       load_done;
    logic [7:0] out_data;
    logic       out_valid;
    logic       cf;
    logic       zf;
    logic       halted;

    sap_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_mode (prog_mode),
        .prog_valid(prog_valid),
        .prog_data (prog_data),
        .prog_ready(prog_ready),
        .load_done (load_done),
        .out_data  (out_data),
        .out_valid (out_valid),
        .cf        (cf),
        .zf        (zf),
        .halted    (halted)
    );

    typedef struct {
        bit         is_halt;
        logic [7:0] data;
        int         cyc;
        logic       cf;
        logic       zf;
    } ev_t;

    ev_t        sb[$];
    logic [7:0] mmem [16];
    logic [7:0] pbuf [16];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         t0 = 0;
    int         win_r = 0;
    bit         mon_active = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_cf", cf, 0);
        check("rst_zf", zf, 0);
        check("rst_halted", halted, 0);
        check("rst_prog_ready", prog_ready, 0);
        check("rst_load_done", load_done, 0);
    endtask

    // Instruction-level model: run from PC=0 with cleared registers, push timed events.
    task automatic model_run(input int win, input bit do_rst);
        logic [3:0] pc  = 4'd0;
        logic [7:0] a   = 8'd0;
        logic [7:0] w;
        logic [7:0] m;
        logic       mcf = 1'b0;
        logic       mzf = 1'b0;
        int         t   = 0;
        int         len;
        int         sum;
        bit         done = 1'b0;
        ev_t        ev;
        while (t < win && !done) begin
            w   = mmem[pc];
            m   = mmem[w[3:0]];
            pc  = pc + 4'd1;
            len = 3;
            case (w[7:4])
                4'h1: begin a = m; len = 4; end
                4'h2: begin
                    sum = int'(a) + int'(m);
                    a = sum[7:0]; mcf = (sum > 255); mzf = (a == 8'd0); len = 5;
                end
                4'h3: begin
                    mcf = (a >= m); a = a - m; mzf = (a == 8'd0); len = 5;
                end
                4'h4: begin
                    if (!do_rst || (t + 3 < win - 1)) mmem[w[3:0]] = a;
                    len = 4;
                end
                4'h5: a = {4'h0, w[3:0]};
                4'h6: pc = w[3:0];
                4'h7: if (mcf) pc = w[3:0];
                4'h8: if (mzf) pc = w[3:0];
                4'hE: begin
                    if (t + 3 < win) begin
                        ev.is_halt = 1'b0; ev.data = a; ev.cyc = t + 3; ev.cf = mcf; ev.zf = mzf;
                        sb.push_back(ev);
                    end
                end
                4'hF: begin
                    if (t + 3 < win) begin
                        ev.is_halt = 1'b1; ev.data = a; ev.cyc = t + 3; ev.cf = mcf; ev.zf = mzf;
                        sb.push_back(ev);
                    end
                    done = 1'b1;
                end
                default: len = 3;
            endcase
            t += len;
        end
    endtask

    // Monitor: pop and compare whenever the core shows an output pulse or enters HALT.
    initial begin
        ev_t ev;
        logic halted_q;
        int rel;
        halted_q = 1'b0;
        forever begin
            @(negedge clk);
            rel = cyc - t0;
            if (mon_active && rel < win_r) begin
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_out: got data %0h at cycle %0d, expected no output", out_data, rel);
                    end else begin
                        ev = sb.pop_front();
                        check("out_kind_halt", ev.is_halt, 0);
                        check("out_data", out_data, ev.data);
                        check("out_cycle", rel, ev.cyc);
                    end
                end
                if (halted && !halted_q) begin
                    if (sb.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_halt: got halt at cycle %0d, expected none", rel);
                    end else begin
                        ev = sb.pop_front();
                        check("halt_kind", ev.is_halt, 1);
                        check("halt_cycle", rel, ev.cyc);
                        check("halt_cf", cf, ev.cf);
                        check("halt_zf", zf, ev.zf);
                    end
                end
            end
            halted_q = halted;
        end
    end

    // Load n words from pbuf with random valid gaps, then hold valid for extra cycles.
    task automatic load_prog(input int n, input int extra);
        int mptr = 0;
        int ex = extra;
        prog_mode  = 1'b1;
        prog_valid = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 400; k++) begin
            #1;
            if (mptr < n) begin
                prog_valid = 1'($urandom_range(0, 1));
                prog_data  = pbuf[mptr];
            end else if (ex > 0) begin
                prog_valid = 1'b1;
                prog_data  = 8'($urandom);
                ex--;
            end else begin
                break;
            end
            @(negedge clk);
            check("prog_ready", prog_ready, (mptr < 16));
            check("load_done", load_done, (mptr == 16));
            if (prog_valid && mptr < 16) begin
                mmem[mptr] = prog_data;
                mptr++;
            end
            @(posedge clk);
        end
        prog_valid = 1'b0;
        prog_mode  = 1'b0;
    endtask

    task automatic run_prog(input int win, input bit do_rst);
        @(posedge clk);
        #1;
        t0    = cyc;
        win_r = win;
        model_run(win, do_rst);
        mon_active = 1'b1;
        repeat (win - 1) @(posedge clk);
        #1;
        if (do_rst) rst = 1'b1;
        @(posedge clk);
        #1;
        mon_active = 1'b0;
        check("sb_leftover", sb.size(), 0);
        sb.delete();
        if (do_rst) begin
            rst = 1'b0;
            check_reset_outputs();
        end
    endtask

    task automatic clear_pbuf();
        for (int i = 0; i < 16; i++) pbuf[i] = 8'h00;
    endtask

    initial begin
        int exp_len;
        int n;
        logic [3:0] op;
        rst = 1'b1; prog_mode = 1'b0; prog_valid = 1'b0; prog_data = 8'h00;
        for (int i = 0; i < 16; i++) mmem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            op = 4'(i);
            exp_len = (i == 1 || i == 4) ? 4 : ((i == 2 || i == 3) ? 5 : 3);
            check("instr_len", 32'(instr_len(op)), exp_len);
        end

        // Add then halt, with extra valid beats after the full load.
        clear_pbuf();
        pbuf[0] = 8'h1E; pbuf[1] = 8'h2F; pbuf[2] = 8'hE0; pbuf[3] = 8'hF0;
        pbuf[14] = 8'h1C; pbuf[15] = 8'h0E;
        load_prog(16, 3);
        run_prog(30, 1'b0);

        // Carry out of ADD then JC taken.
        clear_pbuf();
        pbuf[0] = 8'h1E; pbuf[1] = 8'h2F; pbuf[2] = 8'h75; pbuf[3] = 8'hE0; pbuf[4] = 8'hF0;
        pbuf[5] = 8'h57; pbuf[6] = 8'hE0; pbuf[7] = 8'hF0;
        pbuf[14] = 8'hFF; pbuf[15] = 8'h01;
        load_prog(16, 0);
        run_prog(40, 1'b0);

        // SUB with borrow, JZ not taken.
        clear_pbuf();
        pbuf[0] = 8'h1E; pbuf[1] = 8'h3F; pbuf[2] = 8'h86; pbuf[3] = 8'hE0; pbuf[4] = 8'hF0;
        pbuf[6] = 8'h51; pbuf[7] = 8'hE0; pbuf[8] = 8'hF0;
        pbuf[14] = 8'h05; pbuf[15] = 8'h07;
        load_prog(16, 0);
        run_prog(40, 1'b0);

        // Early exit after three words; the rest of RAM keeps the previous program.
        clear_pbuf();
        pbuf[0] = 8'h5A; pbuf[1] = 8'hE0; pbuf[2] = 8'h1E;
        load_prog(3, 0);
        run_prog(60, 1'b0);

        // Reset during ADD T4, then rerun the retained program without loading.
        clear_pbuf();
        pbuf[0] = 8'h1E; pbuf[1] = 8'h2F; pbuf[2] = 8'hE0; pbuf[3] = 8'hF0;
        pbuf[14] = 8'h1C; pbuf[15] = 8'h0E;
        load_prog(16, 0);
        run_prog(8, 1'b1);
        run_prog(30, 1'b0);

        // PC wrap: OUT at 0, NOPs, STA at 15.
        clear_pbuf();
        pbuf[0] = 8'hE0; pbuf[15] = 8'h4E;
        load_prog(16, 0);
        run_prog(120, 1'b1);

        // Random programs, full or partial loads, each ended by reset.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) pbuf[i] = 8'($urandom);
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
            load_prog(n, (n == 16) ? 2 : 0);
            run_prog(150, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
